// File: rtl/debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// debounced_updown_counter
//   Up/down event counter driven by raw switch/button inputs. Each raw input
//   is synchronised (2 flops), debounced (DB_CYCLES stable clocks), and
//   rising-edge detected. Each detected edge adds or subtracts one. At the
//   limits the count either wraps or saturates at MAX_VAL. A synchronous
//   parallel load is also supported.
//
// Parameters
//   WIDTH      count width in bits
//   MAX_VAL    terminal count, 1 .. 2**WIDTH-1
//   DB_CYCLES  consecutive stable clocks needed to accept a change, >= 1
//   SATURATE   0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   inc, dec    asynchronous raw increment / decrement levels
//   en          step enable (synchronous)
//   load        parallel load strobe (synchronous)
//   load_val    value to load, clamped to MAX_VAL
//   count       current count (registered)
//   at_max      count == MAX_VAL (decoded from the count register)
//   at_min      count == 0       (decoded from the count register)
//   wrap_pulse  registered one-cycle pulse on each wrap event
// ---------------------------------------------------------------------------
module debounced_updown_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VAL   = (1 << WIDTH) - 1,
   parameter int unsigned DB_CYCLES = 4,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap_pulse
);

   localparam int unsigned     LP_DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [LP_DBW-1:0] LP_DB_LAST = LP_DBW'(DB_CYCLES - 1);
   localparam logic [WIDTH-1:0]  LP_MAX     = WIDTH'(MAX_VAL);
   localparam int unsigned     LP_NIN     = 2;   // index 0 = inc, 1 = dec

   // Parameter sanity checks at elaboration
   if (DB_CYCLES < 1) begin : g_bad_db
      $error("DB_CYCLES must be at least 1");
   end
   if (MAX_VAL < 1) begin : g_bad_max_lo
      $error("MAX_VAL must be at least 1");
   end
   if (WIDTH < 32 && MAX_VAL > ((1 << WIDTH) - 1)) begin : g_bad_max_hi
      $error("MAX_VAL does not fit in WIDTH bits");
   end

   // -----------------------------------------------------------------------
   // Registers and combinational nets
   // -----------------------------------------------------------------------
   logic [LP_NIN-1:0] r_sync1;
   logic [LP_NIN-1:0] r_sync2;
   logic [LP_NIN-1:0] r_filt;
   logic [LP_NIN-1:0] r_filt_d;
   logic [LP_DBW-1:0] r_db_cnt [LP_NIN];

   logic [WIDTH-1:0]  r_count;
   logic              r_wrap;

   logic              w_step_up;
   logic              w_step_dn;
   logic [WIDTH-1:0]  w_load_clamped;
   logic [WIDTH-1:0]  w_count_nxt;
   logic              w_wrap_nxt;

   // -----------------------------------------------------------------------
   // Two-flop synchronisers for the raw asynchronous inputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {dec, inc};
         r_sync2 <= r_sync1;
      end
   end

   // -----------------------------------------------------------------------
   // Debouncers: filt flips on the DB_CYCLES-th consecutive mismatching edge;
   // any matching edge restarts the count.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt <= '0;
         for (int i = 0; i < int'(LP_NIN); i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(LP_NIN); i++) begin
            if (r_sync2[i] != r_filt[i]) begin
               if (r_db_cnt[i] == LP_DB_LAST) begin
                  r_filt[i]   <= ~r_filt[i];
                  r_db_cnt[i] <= '0;
               end else begin
                  r_db_cnt[i] <= r_db_cnt[i] + LP_DBW'(1);
               end
            end else begin
               r_db_cnt[i] <= '0;
            end
         end
      end
   end

   // Delayed filtered level for edge detection; tracks even while en=0 so
   // a press held across re-enable is not replayed as a fresh step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt_d <= '0;
      end else begin
         r_filt_d <= r_filt;
      end
   end

   assign w_step_up = r_filt[0] & ~r_filt_d[0];
   assign w_step_dn = r_filt[1] & ~r_filt_d[1];

   assign w_load_clamped = (load_val > LP_MAX) ? LP_MAX : load_val;

   // -----------------------------------------------------------------------
   // Next count and wrap flag: load beats steps; opposing steps cancel.
   // -----------------------------------------------------------------------
   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      if (load) begin
         w_count_nxt = w_load_clamped;
      end else if (en && (w_step_up != w_step_dn)) begin
         if (w_step_up) begin
            if (r_count >= LP_MAX) begin
               if (!SATURATE) begin
                  w_count_nxt = '0;
                  w_wrap_nxt  = 1'b1;
               end
            end else begin
               w_count_nxt = r_count + WIDTH'(1);
            end
         end else begin
            if (r_count == '0) begin
               if (!SATURATE) begin
                  w_count_nxt = LP_MAX;
                  w_wrap_nxt  = 1'b1;
               end
            end else begin
               w_count_nxt = r_count - WIDTH'(1);
            end
         end
      end
   end

   // Count and wrap pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign count      = r_count;
   assign wrap_pulse = r_wrap;
   assign at_max     = (r_count == LP_MAX);
   assign at_min     = (r_count == '0);

endmodule

// File: tb/tb_debounced_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_debounced_updown_counter
//   Three instances share one stimulus stream:
//     A: WIDTH=8, MAX_VAL=255, wrap
//     B: WIDTH=4, MAX_VAL=9,   wrap
//     C: WIDTH=4, MAX_VAL=9,   saturate
//   Expected results are queued when stimulus is applied and compared when
//   the corresponding output is sampled (on the falling edge).
// ---------------------------------------------------------------------------
module tb_debounced_updown_counter;

   logic       clk = 1'b0;
   logic       rst, inc, dec, en, load;
   logic [7:0] load_val;

   logic [7:0] a_count;
   logic [3:0] b_count, c_count;
   logic       a_max, a_min, a_wrap;
   logic       b_max, b_min, b_wrap;
   logic       c_max, c_min, c_wrap;

   always #5 clk = ~clk;

   debounced_updown_counter #(.WIDTH(8), .MAX_VAL(255), .DB_CYCLES(4), .SATURATE(1'b0)) u_a (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .en(en), .load(load),
      .load_val(load_val), .count(a_count), .at_max(a_max), .at_min(a_min),
      .wrap_pulse(a_wrap));

   debounced_updown_counter #(.WIDTH(4), .MAX_VAL(9), .DB_CYCLES(4), .SATURATE(1'b0)) u_b (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .en(en), .load(load),
      .load_val(load_val[3:0]), .count(b_count), .at_max(b_max), .at_min(b_min),
      .wrap_pulse(b_wrap));

   debounced_updown_counter #(.WIDTH(4), .MAX_VAL(9), .DB_CYCLES(4), .SATURATE(1'b1)) u_c (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .en(en), .load(load),
      .load_val(load_val[3:0]), .count(c_count), .at_max(c_max), .at_min(c_min),
      .wrap_pulse(c_wrap));

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [3:0] b;
      logic [3:0] c;
      logic       wa;
      logic       wb;
      logic       wc;
   } exp_t;

   typedef struct {
      string      name;
      logic       rst;
      logic       inc;
      logic       dec;
      logic       en;
      logic       load;
      logic [7:0] lv;
      int         cyc;
      logic [7:0] a;
      logic [3:0] b;
      logic [3:0] c;
   } vec_t;

   exp_t sb_q[$];
   vec_t vt[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   a_wraps = 0;
   int   b_wraps = 0;
   int   c_wraps = 0;

   // Running wrap-pulse tallies over the whole run
   always @(negedge clk) begin
      if (a_wrap === 1'b1) a_wraps++;
      if (b_wrap === 1'b1) b_wraps++;
      if (c_wrap === 1'b1) c_wraps++;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_exp(input string n, input logic [7:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic wa, input logic wb, input logic wc);
      exp_t e;
      e.name = n; e.a = a; e.b = b; e.c = c; e.wa = wa; e.wb = wb; e.wc = wc;
      sb_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_total++;
         $display("FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = sb_q.pop_front();
      chk({e.name, ":a_count"}, a_count, e.a);
      chk({e.name, ":a_min"},   8'(a_min),  8'(e.a == 8'd0));
      chk({e.name, ":a_max"},   8'(a_max),  8'(e.a == 8'd255));
      chk({e.name, ":a_wrap"},  8'(a_wrap), 8'(e.wa));
      chk({e.name, ":b_count"}, 8'(b_count), 8'(e.b));
      chk({e.name, ":b_min"},   8'(b_min),  8'(e.b == 4'd0));
      chk({e.name, ":b_max"},   8'(b_max),  8'(e.b == 4'd9));
      chk({e.name, ":b_wrap"},  8'(b_wrap), 8'(e.wb));
      chk({e.name, ":c_count"}, 8'(c_count), 8'(e.c));
      chk({e.name, ":c_min"},   8'(c_min),  8'(e.c == 4'd0));
      chk({e.name, ":c_max"},   8'(c_max),  8'(e.c == 4'd9));
      chk({e.name, ":c_wrap"},  8'(c_wrap), 8'(e.wc));
   endtask

   // Expect the same values for one sampled cycle, no wrap pulses
   task automatic step_chk(input string n, input logic [7:0] a, input logic [3:0] b,
                           input logic [3:0] c);
      push_exp(n, a, b, c, 1'b0, 1'b0, 1'b0);
      tick();
      pop_check();
   endtask

   task automatic add_row(input string n, input logic r, input logic i, input logic d,
                          input logic e, input logic ld, input logic [7:0] lv, input int cyc,
                          input logic [7:0] a, input logic [3:0] b, input logic [3:0] c);
      vec_t v;
      v.name = n; v.rst = r; v.inc = i; v.dec = d; v.en = e; v.load = ld; v.lv = lv;
      v.cyc = cyc; v.a = a; v.b = b; v.c = c;
      vt.push_back(v);
   endtask

   // A press held 8 clocks then released for 12 clocks
   task automatic add_press(input string n, input logic i, input logic d, input logic e,
                            input logic [7:0] a, input logic [3:0] b, input logic [3:0] c);
      add_row({n, "_hold"}, 1'b0, i, d, e, 1'b0, 8'd0, 8, a, b, c);
      add_row({n, "_rel"},  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 12, a, b, c);
   endtask

   initial begin
      rst = 1'b1; inc = 1'b0; dec = 1'b0; en = 1'b1; load = 1'b0; load_val = 8'd0;

      // Reset held for 3 clocks
      for (int k = 0; k < 3; k++) step_chk("reset", 8'd0, 4'd0, 4'd0);

      // Basic step latency: count changes exactly 6 edges after inc is sampled
      rst = 1'b0; inc = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         if (k >= 7) step_chk("basic_step", 8'd1, 4'd1, 4'd1);
         else        step_chk("basic_wait", 8'd0, 4'd0, 4'd0);
      end
      inc = 1'b0;
      repeat (12) tick();

      // Glitch rejection: 3-clock pulse ignored, 4-clock pulse accepted
      inc = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         step_chk("glitch3", 8'd1, 4'd1, 4'd1);
         if (k == 3) inc = 1'b0;
      end
      inc = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k >= 7) step_chk("pulse4_step", 8'd2, 4'd2, 4'd2);
         else        step_chk("pulse4_wait", 8'd1, 4'd1, 4'd1);
         if (k == 4) inc = 1'b0;
      end

      // Table-driven loads and presses
      add_row  ("load9",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd9,   1, 8'd9,   4'd9, 4'd9);
      add_press("inc_at_max", 1'b1, 1'b0, 1'b1,                   8'd10,  4'd0, 4'd9);
      add_press("dec_at_min", 1'b0, 1'b1, 1'b1,                   8'd9,   4'd9, 4'd8);
      add_row  ("load15", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd15,  1, 8'd15,  4'd9, 4'd9);
      add_press("inc_sat1", 1'b1, 1'b0, 1'b1,                     8'd16,  4'd0, 4'd9);
      add_press("inc_sat2", 1'b1, 1'b0, 1'b1,                     8'd17,  4'd1, 4'd9);
      add_press("inc_sat3", 1'b1, 1'b0, 1'b1,                     8'd18,  4'd2, 4'd9);
      add_row  ("load0",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1, 8'd0,   4'd0, 4'd0);
      add_press("dec_from0", 1'b0, 1'b1, 1'b1,                    8'd255, 4'd9, 4'd0);
      add_row  ("load5",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5,   1, 8'd5,   4'd5, 4'd5);
      add_press("inc_dec_same", 1'b1, 1'b1, 1'b1,                 8'd5,   4'd5, 4'd5);
      add_row  ("load200",1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 1, 8'd200, 4'd8, 4'd8);
      add_press("dec_mid", 1'b0, 1'b1, 1'b1,                      8'd199, 4'd7, 4'd7);
      add_press("inc_en0", 1'b1, 1'b0, 1'b0,                      8'd199, 4'd7, 4'd7);

      foreach (vt[i]) begin
         rst = vt[i].rst; inc = vt[i].inc; dec = vt[i].dec; en = vt[i].en;
         load = vt[i].load; load_val = vt[i].lv;
         push_exp(vt[i].name, vt[i].a, vt[i].b, vt[i].c, 1'b0, 1'b0, 1'b0);
         repeat (vt[i].cyc) tick();
         pop_check();
      end
      rst = 1'b0; inc = 1'b0; dec = 1'b0; en = 1'b1; load = 1'b0; load_val = 8'd0;

      // Wrap pulse timing and width
      load = 1'b1; load_val = 8'd9;
      step_chk("wrap_load9", 8'd9, 4'd9, 4'd9);
      load = 1'b0; inc = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         push_exp("wrap_up", (k >= 7) ? 8'd10 : 8'd9, (k >= 7) ? 4'd0 : 4'd9, 4'd9,
                  1'b0, (k == 7), 1'b0);
         tick();
         pop_check();
      end
      inc = 1'b0;
      repeat (12) tick();
      dec = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         push_exp("wrap_dn", (k >= 7) ? 8'd9 : 8'd10, (k >= 7) ? 4'd9 : 4'd0,
                  (k >= 7) ? 4'd8 : 4'd9, 1'b0, (k == 7), 1'b0);
         tick();
         pop_check();
      end
      dec = 1'b0;
      repeat (12) tick();

      // Load in the same cycle as a step_up: load wins, step discarded
      inc = 1'b1;
      for (int k = 1; k <= 6; k++) step_chk("ldstep_wait", 8'd9, 4'd9, 4'd8);
      load = 1'b1; load_val = 8'd2;
      step_chk("ldstep_load", 8'd2, 4'd2, 4'd2);
      load = 1'b0;
      for (int k = 1; k <= 10; k++) step_chk("ldstep_hold", 8'd2, 4'd2, 4'd2);
      inc = 1'b0;
      repeat (12) tick();

      // Enable low during a press, re-enabled while still held
      en = 1'b0; inc = 1'b1;
      for (int k = 1; k <= 10; k++) step_chk("en_off", 8'd2, 4'd2, 4'd2);
      en = 1'b1;
      for (int k = 1; k <= 10; k++) step_chk("en_back", 8'd2, 4'd2, 4'd2);
      inc = 1'b0;
      for (int k = 1; k <= 12; k++) step_chk("en_rel", 8'd2, 4'd2, 4'd2);

      // Reset two clocks into a debounce, inc held through and after reset
      inc = 1'b1;
      for (int k = 1; k <= 2; k++) step_chk("rstmid_pre", 8'd2, 4'd2, 4'd2);
      rst = 1'b1;
      for (int k = 1; k <= 2; k++) step_chk("rstmid_rst", 8'd0, 4'd0, 4'd0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k >= 7) step_chk("rstmid_step", 8'd1, 4'd1, 4'd1);
         else        step_chk("rstmid_wait", 8'd0, 4'd0, 4'd0);
      end
      inc = 1'b0;
      repeat (12) tick();
      step_chk("final", 8'd1, 4'd1, 4'd1);

      // Whole-run wrap pulse totals (one cycle each)
      chk("a_wrap_total", 8'(a_wraps), 8'd1);
      chk("b_wrap_total", 8'(b_wraps), 8'd6);
      chk("c_wrap_total", 8'(c_wraps), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
